// File: rtl/fost_pkg.sv
// Shared types for the fost core data-memory path: default word and register-address
// types, the memory-stage state encoding and the wait-counter width.
package fost_pkg;

  localparam int unsigned WordW    = 16;
  localparam int unsigned RegAddrW = 4;
  // Wait-state counter width; covers 0..15 extra cycles.
  localparam int unsigned CntW     = 4;

  typedef logic [WordW-1:0]    word_t;
  typedef logic [RegAddrW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter for the memory stage: loads a start value, counts down to zero
// and flags zero. clr aborts an in-progress count.
module mem_wait_counter import fost_pkg::*; #(
  parameter int unsigned Width = CntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  // Count register: clear beats load, load beats decrement; saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_stage.sv
// Data-memory pipeline stage: DEPTH-word register-file memory with WAIT_CYCLES extra
// cycles per access behind a ready/valid handshake. Loads produce a one-cycle write-back
// record; flush aborts accepted and offered work.
// Optional feature: define MEM_FAULT_EN to fault (and suppress) accesses with ea >= DEPTH;
// otherwise the index wraps modulo DEPTH and fault stays 0.
module mem_stage import fost_pkg::*; #(
  parameter int unsigned DATA_W      = WordW,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned REG_ADDR_W  = RegAddrW,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_mem_read,
  input  logic                  is_mem_write,
  input  logic                  is_reg_write,
  input  logic [DATA_W-1:0]     base,
  input  logic [DATA_W-1:0]     offset,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_reg_addr,
  output logic                  fault
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  mem_state_e state_q;

  logic                  accept;
  logic                  access;
  logic                  cnt_zero;
  logic                  req_fault;
  logic [DATA_W-1:0]     ea;
  logic                  ea_oob;

  logic                  req_read_q;
  logic                  req_write_q;
  logic                  req_reg_write_q;
  logic                  req_oob_q;
  logic [IdxW-1:0]       req_idx_q;
  logic [DATA_W-1:0]     req_wdata_q;
  logic [REG_ADDR_W-1:0] req_rd_q;

  logic [DATA_W-1:0]     mem_q [DEPTH];

  assign ea     = base + offset;
  assign ea_oob = (ea >> IdxW) != '0;

  // Ready is a pure state decode, held low while reset is asserted.
  assign req_ready = rst & (state_q != StWait);
  assign accept    = req_valid & req_ready & ~flush;
  // The access commits on the edge that leaves DONE, unless flushed.
  assign access    = (state_q == StDone) & ~flush;

`ifdef MEM_FAULT_EN
  assign req_fault = req_oob_q;
`else
  assign req_fault = 1'b0;
  logic unused_oob;
  assign unused_oob = req_oob_q;
`endif

  if (WAIT_CYCLES > 0) begin : g_wait
    localparam logic [CntW-1:0] WaitLoad = CntW'(WAIT_CYCLES - 1);

    mem_wait_counter #(
      .Width (CntW)
    ) u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .load     (accept),
      .load_val (WaitLoad),
      .dec      (state_q == StWait),
      .zero     (cnt_zero)
    );
  end else begin : g_no_wait
    assign cnt_zero = 1'b1;
  end

  // Control FSM, request register and registered write-back/fault outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      req_read_q      <= 1'b0;
      req_write_q     <= 1'b0;
      req_reg_write_q <= 1'b0;
      req_oob_q       <= 1'b0;
      req_idx_q       <= '0;
      req_wdata_q     <= '0;
      req_rd_q        <= '0;
      wb_valid        <= 1'b0;
      wb_data         <= '0;
      wb_reg_addr     <= '0;
      fault           <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_reg_addr <= '0;
      fault       <= 1'b0;

      if (access) begin
        if (req_fault) begin
          fault <= 1'b1;
        end else if (req_read_q) begin
          wb_data     <= mem_q[req_idx_q];
          wb_reg_addr <= req_rd_q;
          wb_valid    <= req_reg_write_q;
        end
      end

      if (flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (accept) begin
              state_q <= (WAIT_CYCLES > 0) ? StWait : StDone;
            end else begin
              state_q <= StIdle;
            end
          end
          StWait: begin
            if (cnt_zero) begin
              state_q <= StDone;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      if (accept) begin
        req_read_q      <= is_mem_read;
        req_write_q     <= is_mem_write;
        req_reg_write_q <= is_reg_write;
        req_oob_q       <= ea_oob;
        req_idx_q       <= ea[IdxW-1:0];
        req_wdata_q     <= wdata;
        req_rd_q        <= rd_addr;
      end
    end
  end

  // Memory array; a store commits on the same edge a combined load samples the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (access && req_write_q && !req_fault) begin
      mem_q[req_idx_q] <= req_wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance with no wait states (index 0) and one with
// two wait states (index 1), sharing clock and reset.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        flush        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        is_mem_read  [2];
  logic        is_mem_write [2];
  logic        is_reg_write [2];
  logic [15:0] base         [2];
  logic [15:0] offset       [2];
  logic [15:0] wdata        [2];
  logic [3:0]  rd_addr      [2];
  logic        wb_valid     [2];
  logic [15:0] wb_data      [2];
  logic [3:0]  wb_reg_addr  [2];
  logic        fault        [2];

  int total = 0;
  int bad   = 0;

  mem_stage #(
    .DATA_W      (16),
    .DEPTH       (64),
    .REG_ADDR_W  (4),
    .WAIT_CYCLES (0)
  ) u_dut0 (
    .rst          (rst),
    .clk          (clk),
    .flush        (flush[0]),
    .req_valid    (req_valid[0]),
    .req_ready    (req_ready[0]),
    .is_mem_read  (is_mem_read[0]),
    .is_mem_write (is_mem_write[0]),
    .is_reg_write (is_reg_write[0]),
    .base         (base[0]),
    .offset       (offset[0]),
    .wdata        (wdata[0]),
    .rd_addr      (rd_addr[0]),
    .wb_valid     (wb_valid[0]),
    .wb_data      (wb_data[0]),
    .wb_reg_addr  (wb_reg_addr[0]),
    .fault        (fault[0])
  );

  mem_stage #(
    .DATA_W      (16),
    .DEPTH       (64),
    .REG_ADDR_W  (4),
    .WAIT_CYCLES (2)
  ) u_dut2 (
    .rst          (rst),
    .clk          (clk),
    .flush        (flush[1]),
    .req_valid    (req_valid[1]),
    .req_ready    (req_ready[1]),
    .is_mem_read  (is_mem_read[1]),
    .is_mem_write (is_mem_write[1]),
    .is_reg_write (is_reg_write[1]),
    .base         (base[1]),
    .offset       (offset[1]),
    .wdata        (wdata[1]),
    .rd_addr      (rd_addr[1]),
    .wb_valid     (wb_valid[1]),
    .wb_data      (wb_data[1]),
    .wb_reg_addr  (wb_reg_addr[1]),
    .fault        (fault[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int d, input logic rd, input logic wr, input logic rw,
                       input logic [15:0] b, input logic [15:0] o, input logic [15:0] wd,
                       input logic [3:0] ra);
    req_valid[d]    = 1'b1;
    is_mem_read[d]  = rd;
    is_mem_write[d] = wr;
    is_reg_write[d] = rw;
    base[d]         = b;
    offset[d]       = o;
    wdata[d]        = wd;
    rd_addr[d]      = ra;
  endtask

  task automatic idle(input int d);
    req_valid[d]    = 1'b0;
    is_mem_read[d]  = 1'b0;
    is_mem_write[d] = 1'b0;
    is_reg_write[d] = 1'b0;
  endtask

  // Issue from an idle stage, wait the fixed latency and check the write-back record.
  task automatic op(input int d, input logic rd, input logic wr, input logic rw,
                    input logic [15:0] b, input logic [15:0] o, input logic [15:0] wd,
                    input logic [3:0] ra, input string tag, input logic exp_v,
                    input logic [15:0] exp_data, input logic [3:0] exp_ra);
    int lat;
    lat = (d == 0) ? 1 : 3;
    issue(d, rd, wr, rw, b, o, wd, ra);
    step();
    idle(d);
    for (int k = 0; k < lat; k++) step();
    chk_bit({tag, "_wbv"}, wb_valid[d], exp_v);
    chk_word({tag, "_data"}, wb_data[d], exp_data);
    chk_word({tag, "_ra"}, {12'd0, wb_reg_addr[d]}, {12'd0, exp_ra});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d]   = 1'b0;
      idle(d);
      base[d]    = '0;
      offset[d]  = '0;
      wdata[d]   = '0;
      rd_addr[d] = '0;
    end
    step();
    step();
    chk_bit("rst_ready0", req_ready[0], 1'b0);
    chk_bit("rst_wbv1", wb_valid[1], 1'b0);
    rst = 1'b1;
    #1;
    chk_bit("rel_ready0", req_ready[0], 1'b1);
    chk_bit("rel_ready1", req_ready[1], 1'b1);
    step();

    // No wait states: store 10 to index 1, back-to-back load of the same word.
    issue(0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0, 16'd10, 4'd0);
    step();
    chk_bit("w0_done_ready", req_ready[0], 1'b1);
    issue(0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1, 16'd0, 4'd3);
    step();
    chk_bit("w0_store_wbv", wb_valid[0], 1'b0);
    idle(0);
    step();
    chk_bit("w0_load_wbv", wb_valid[0], 1'b1);
    chk_word("w0_load_data", wb_data[0], 16'd10);
    chk_word("w0_load_ra", {12'd0, wb_reg_addr[0]}, 16'd3);
    step();
    chk_bit("w0_pulse_end_v", wb_valid[0], 1'b0);
    chk_word("w0_pulse_end_d", wb_data[0], 16'd0);

    // Two wait states: store 4 to index 2, then combined load+store (9) back-to-back.
    issue(1, 1'b0, 1'b1, 1'b0, 16'd2, 16'd0, 16'd4, 4'd0);
    chk_bit("w2_idle_ready", req_ready[1], 1'b1);
    step();
    idle(1);
    chk_bit("w2_wait_ready_a", req_ready[1], 1'b0);
    step();
    chk_bit("w2_wait_ready_b", req_ready[1], 1'b0);
    step();
    chk_bit("w2_done_ready", req_ready[1], 1'b1);
    issue(1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 16'd9, 4'd5);
    step();
    idle(1);
    chk_bit("w2_store_wbv", wb_valid[1], 1'b0);
    chk_bit("w2_b2b_accepted", req_ready[1], 1'b0);
    step();
    step();
    chk_bit("w2_not_early", wb_valid[1], 1'b0);
    step();
    chk_bit("ldst_wbv", wb_valid[1], 1'b1);
    chk_word("ldst_old_data", wb_data[1], 16'd4);
    chk_word("ldst_ra", {12'd0, wb_reg_addr[1]}, 16'd5);
    op(1, 1'b1, 1'b0, 1'b1, 16'd2, 16'd0, 16'd0, 4'd6, "ldst_new", 1'b1, 16'd9, 4'd6);

    // Flush during WAIT of a store to index 5: nothing commits, no write-back.
    issue(1, 1'b0, 1'b1, 1'b0, 16'd5, 16'd0, 16'd7, 4'd0);
    step();
    idle(1);
    step();
    flush[1] = 1'b1;
    step();
    flush[1] = 1'b0;
    chk_bit("fl_wbv", wb_valid[1], 1'b0);
    chk_bit("fl_ready", req_ready[1], 1'b1);
    // A request offered under flush must not be accepted.
    flush[1] = 1'b1;
    issue(1, 1'b1, 1'b0, 1'b1, 16'd2, 16'd0, 16'd0, 4'd1);
    step();
    flush[1] = 1'b0;
    idle(1);
    chk_bit("fl_no_accept", req_ready[1], 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_bit("fl_quiet", wb_valid[1], 1'b0);
    end
    op(1, 1'b1, 1'b0, 1'b1, 16'd5, 16'd0, 16'd0, 4'd2, "fl_load5", 1'b1, 16'd0, 4'd2);

    // Out-of-range address: ea = 60 + 10 = 70 (index 6 when wrapping).
    op(1, 1'b0, 1'b1, 1'b0, 16'd6, 16'd0, 16'h0055, 4'd0, "st6", 1'b0, 16'd0, 4'd0);
`ifdef MEM_FAULT_EN
    op(1, 1'b1, 1'b0, 1'b1, 16'd60, 16'd10, 16'd0, 4'd7, "oob", 1'b0, 16'd0, 4'd0);
    chk_bit("oob_fault", fault[1], 1'b1);
`else
    op(1, 1'b1, 1'b0, 1'b1, 16'd60, 16'd10, 16'd0, 4'd7, "oob", 1'b1, 16'h0055, 4'd7);
    chk_bit("oob_fault", fault[1], 1'b0);
`endif
    step();
    chk_bit("oob_fault_end", fault[1], 1'b0);
    chk_bit("w0_fault_idle", fault[0], 1'b0);

    // Reset mid-WAIT while a write-back pulse is on the outputs.
    issue(1, 1'b1, 1'b0, 1'b1, 16'd6, 16'd0, 16'd0, 4'd9);
    step();
    idle(1);
    step();
    step();
    issue(1, 1'b1, 1'b0, 1'b1, 16'd6, 16'd0, 16'd0, 4'd10);
    step();
    idle(1);
    chk_bit("rs_pre_wbv", wb_valid[1], 1'b1);
    chk_word("rs_pre_data", wb_data[1], 16'h0055);
    chk_word("rs_pre_ra", {12'd0, wb_reg_addr[1]}, 16'd9);
    #2;
    rst = 1'b0;
    #1;
    chk_bit("rs_wbv", wb_valid[1], 1'b0);
    chk_word("rs_data", wb_data[1], 16'd0);
    chk_word("rs_ra", {12'd0, wb_reg_addr[1]}, 16'd0);
    chk_bit("rs_ready", req_ready[1], 1'b0);
    chk_bit("rs_fault", fault[1], 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk_bit("rs_rel_ready", req_ready[1], 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_bit("rs_no_stale_wb", wb_valid[1], 1'b0);
    end
    op(1, 1'b1, 1'b0, 1'b1, 16'd6, 16'd0, 16'd0, 4'd11, "rs_mem1", 1'b1, 16'd0, 4'd11);
    op(0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0, 16'd0, 4'd1, "rs_mem0", 1'b1, 16'd0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
